// File: rtl/seq_pattern_detector_if.sv
// Detector bundle: soft clear and qualified serial bit in; match pulse, progress, count and saturation out.
// The bench or upstream logic drives through master; the detector connects to slave.
interface seq_pattern_detector_if #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
);
    localparam int PW = $clog2(PAT_LEN + 1);

    logic             clr;
    logic             in_valid;
    logic             in_bit;
    logic             match;
    logic [PW-1:0]    progress;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (
        output clr, in_valid, in_bit,
        input  match, progress, match_cnt, cnt_sat
    );

    modport slave (
        input  clr, in_valid, in_bit,
        output match, progress, match_cnt, cnt_sat
    );
endinterface

// File: rtl/seq_pattern_detector.sv
// Serial PAT_LEN-bit pattern detector (KMP automaton) with saturating match counter; optional idle timeout via SEQ_DET_TIMEOUT_EN.
// Latency: match pulses one cycle after the completing accepted bit; all outputs registered.
// Backpressure: none; a bit is consumed on every in_valid cycle, gaps hold progress.
module seq_pattern_detector #(
    parameter int               PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8,
    parameter int               TO_CYC  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_pattern_detector_if.slave sp
);
    localparam int PW = $clog2(PAT_LEN + 1);
    localparam int NS = 1 << PW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (PAT_LEN < 2 || PAT_LEN > 32) begin : g_bad_len
        $error("seq_pattern_detector: PAT_LEN must be 2..32");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt
        $error("seq_pattern_detector: CNT_W must be 1..32");
    end
    if (TO_CYC < 1) begin : g_bad_to
        $error("seq_pattern_detector: TO_CYC must be >= 1");
    end

    // Bit i of the pattern in arrival order (i=0 is the first bit received).
    function automatic logic pat_bit(int i);
        logic [PAT_LEN-1:0] t;
        t = PATTERN >> (PAT_LEN - 1 - i);
        return t[0];
    endfunction

    // Longest pattern prefix that is a suffix of (prefix of length p, then b).
    function automatic int kmp_next(int p, logic b);
        int   res;
        int   len;
        int   idx;
        logic ok;
        logic sb;
        res = 0;
        len = p + 1;
        if (p < PAT_LEN) begin
            for (int k = 1; k < PAT_LEN; k++) begin
                if (k <= len) begin
                    ok = 1'b1;
                    for (int j = 0; j < PAT_LEN; j++) begin
                        if (j < k) begin
                            idx = len - k + j;
                            sb  = (idx < p) ? pat_bit(idx) : b;
                            if (sb != pat_bit(j)) ok = 1'b0;
                        end
                    end
                    if (ok) res = k;
                end
            end
        end
        return res;
    endfunction

    // Longest proper prefix of the pattern that is also its suffix.
    function automatic int fail_len();
        int   res;
        logic ok;
        res = 0;
        for (int k = 1; k < PAT_LEN; k++) begin
            ok = 1'b1;
            for (int j = 0; j < PAT_LEN; j++) begin
                if (j < k && pat_bit(PAT_LEN - k + j) != pat_bit(j)) ok = 1'b0;
            end
            if (ok) res = k;
        end
        return res;
    endfunction

    localparam logic [PW-1:0] COMPL_P = OVERLAP ? PW'(fail_len()) : '0;

    logic [PW-1:0] nxt0 [NS];
    logic [PW-1:0] nxt1 [NS];

    for (genvar g = 0; g < NS; g++) begin : g_tab
        localparam int N0 = kmp_next(g, 1'b0);
        localparam int N1 = kmp_next(g, 1'b1);
        assign nxt0[g] = PW'(N0);
        assign nxt1[g] = PW'(N1);
    end

    logic [PW-1:0]    p_q;
    logic             match_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;
    logic [PW-1:0]    p_bit;
    logic             done;
    logic [CNT_W-1:0] cnt_inc;
    logic             to_hit;

    always_comb begin
        p_bit   = sp.in_bit ? nxt1[p_q] : nxt0[p_q];
        done    = (p_q == PW'(PAT_LEN - 1)) && (sp.in_bit == PATTERN[0]);
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end

`ifdef SEQ_DET_TIMEOUT_EN
    localparam int IW = $clog2(TO_CYC + 1);
    logic [IW-1:0] idle_q;

    // Fires on the TO_CYC-th consecutive idle cycle with a partial match pending.
    assign to_hit = !sp.in_valid && (p_q != '0) && (idle_q == IW'(TO_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || sp.clr || sp.in_valid || p_q == '0 || to_hit) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_q + IW'(1);
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q     <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else if (sp.clr) begin
            p_q     <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else if (sp.in_valid) begin
            if (done) begin
                match_q <= 1'b1;
                p_q     <= COMPL_P;
                cnt_q   <= cnt_inc;
                if (cnt_inc == CNT_MAX) sat_q <= 1'b1;
            end else begin
                match_q <= 1'b0;
                p_q     <= p_bit;
            end
        end else begin
            match_q <= 1'b0;
            if (to_hit) p_q <= '0;
        end
    end

    assign sp.match     = match_q;
    assign sp.progress  = p_q;
    assign sp.match_cnt = cnt_q;
    assign sp.cnt_sat   = sat_q;
endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench for seq_pattern_detector: three configurations share one stimulus port, selected by sel.
// Stimulus pushes the expected state seen at each match pulse; per-DUT monitors pop and compare.
module tb_seq_pattern_detector;
    logic clk = 1'b0;
    logic rst;
    logic d_vld, d_bit, d_clr;
    int   sel;
    int   ncmp = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    seq_pattern_detector_if #(.PAT_LEN(4), .CNT_W(8)) ifa ();
    seq_pattern_detector_if #(.PAT_LEN(4), .CNT_W(8)) ifb ();
    seq_pattern_detector_if #(.PAT_LEN(4), .CNT_W(2)) ifc ();

    assign ifa.in_valid = d_vld && sel == 0;
    assign ifa.clr      = d_clr && sel == 0;
    assign ifa.in_bit   = d_bit;
    assign ifb.in_valid = d_vld && sel == 1;
    assign ifb.clr      = d_clr && sel == 1;
    assign ifb.in_bit   = d_bit;
    assign ifc.in_valid = d_vld && sel == 2;
    assign ifc.clr      = d_clr && sel == 2;
    assign ifc.in_bit   = d_bit;

    seq_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8), .TO_CYC(16))
        dut_a (.clk(clk), .rst(rst), .sp(ifa));
    seq_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8), .TO_CYC(4))
        dut_b (.clk(clk), .rst(rst), .sp(ifb));
    seq_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(2), .TO_CYC(16))
        dut_c (.clk(clk), .rst(rst), .sp(ifc));

    typedef struct {
        int prog;
        int cnt;
        int sat;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    task automatic chk(input string name, input int act, input int req);
        ncmp++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic chk_match(input string tag, input exp_t e, input int p, input int c, input int s);
        chk({tag, "_prog"}, p, e.prog);
        chk({tag, "_cnt"},  c, e.cnt);
        chk({tag, "_sat"},  s, e.sat);
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (ifa.match) begin
            if (qa.size() == 0) chk("a_unexpected_match", 1, 0);
            else begin
                e = qa.pop_front();
                chk_match("a_match", e, int'(ifa.progress), int'(ifa.match_cnt), int'(ifa.cnt_sat));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (ifb.match) begin
            if (qb.size() == 0) chk("b_unexpected_match", 1, 0);
            else begin
                e = qb.pop_front();
                chk_match("b_match", e, int'(ifb.progress), int'(ifb.match_cnt), int'(ifb.cnt_sat));
            end
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (ifc.match) begin
            if (qc.size() == 0) chk("c_unexpected_match", 1, 0);
            else begin
                e = qc.pop_front();
                chk_match("c_match", e, int'(ifc.progress), int'(ifc.match_cnt), int'(ifc.cnt_sat));
            end
        end
    end

    task automatic drive(input logic v, input logic b, input logic c);
        d_vld = v;
        d_bit = b;
        d_clr = c;
        @(posedge clk);
        #1;
        d_vld = 1'b0;
        d_clr = 1'b0;
    endtask

    // n bits of v, most significant first, back-to-back.
    task automatic bits(input int n, input logic [31:0] v);
        for (int i = n - 1; i >= 0; i--) drive(1'b1, v[i], 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; d_vld = 1'b0; d_bit = 1'b0; d_clr = 1'b0; sel = 0;
        @(posedge clk);
        #1;
        chk("rst_match",   int'(ifa.match), 0);
        chk("rst_prog",    int'(ifa.progress), 0);
        chk("rst_cnt",     int'(ifa.match_cnt), 0);
        chk("rst_sat",     int'(ifa.cnt_sat), 0);
        chk("rst_c_cnt",   int'(ifc.match_cnt), 0);
        rst = 1'b0;

        // Overlapping: 1101101 matches after bits 4 and 7.
        sel = 0;
        qa.push_back('{1, 1, 0});
        qa.push_back('{1, 2, 0});
        bits(7, 7'b1101101);
        chk("t1_prog", int'(ifa.progress), 1);
        chk("t1_cnt",  int'(ifa.match_cnt), 2);
        drive(1'b0, 1'b0, 1'b1);

        // Mismatch fallback onto a nonzero prefix: 111 leaves "11".
        bits(3, 3'b111);
        chk("fb_prog", int'(ifa.progress), 2);
        qa.push_back('{1, 1, 0});
        bits(2, 2'b01);
        drive(1'b0, 1'b0, 1'b1);

        // Gaps hold a partial match.
        bits(3, 3'b110);
        idle(5);
        chk("gap_prog_mid", int'(ifa.progress), 3);
        idle(5);
        chk("gap_prog_end", int'(ifa.progress), 3);
        qa.push_back('{1, 1, 0});
        bits(1, 1'b1);

        // Clear in the same cycle as an accepted bit discards the bit.
        bits(3, 3'b110);
        chk("clr_pre_prog", int'(ifa.progress), 3);
        drive(1'b1, 1'b1, 1'b1);
        chk("clr_prog", int'(ifa.progress), 0);
        chk("clr_cnt",  int'(ifa.match_cnt), 0);
        qa.push_back('{1, 1, 0});
        bits(4, 4'b1101);
        chk("clr_post_cnt", int'(ifa.match_cnt), 1);

        // Non-overlapping: one match; bits 5..7 = 1,0,1 restart and leave P at 1.
        sel = 1;
        drive(1'b0, 1'b0, 1'b1);
        qb.push_back('{0, 1, 0});
        bits(7, 7'b1101101);
        chk("t2_prog", int'(ifb.progress), 1);
        chk("t2_cnt",  int'(ifb.match_cnt), 1);

        // Idle timeout (TO_CYC=4 on this instance).
        drive(1'b0, 1'b0, 1'b1);
        bits(3, 3'b110);
        idle(3);
        chk("to_prog_3idle", int'(ifb.progress), 3);
        idle(1);
`ifdef SEQ_DET_TIMEOUT_EN
        chk("to_prog_4idle", int'(ifb.progress), 0);
        bits(1, 1'b1);
        chk("to_prog_after", int'(ifb.progress), 1);
        chk("to_cnt_after",  int'(ifb.match_cnt), 0);
`else
        chk("to_prog_4idle", int'(ifb.progress), 3);
        qb.push_back('{0, 1, 0});
        bits(1, 1'b1);
        chk("to_prog_after", int'(ifb.progress), 0);
        chk("to_cnt_after",  int'(ifb.match_cnt), 1);
`endif

        // 2-bit counter saturates at 3 on the third of five matches.
        sel = 2;
        qc.push_back('{1, 1, 0});
        qc.push_back('{1, 2, 0});
        qc.push_back('{1, 3, 1});
        qc.push_back('{1, 3, 1});
        qc.push_back('{1, 3, 1});
        bits(16, 16'b1101101101101101);
        chk("sat_cnt", int'(ifc.match_cnt), 3);
        chk("sat_flag", int'(ifc.cnt_sat), 1);
        drive(1'b0, 1'b0, 1'b1);
        chk("sat_clr_cnt",  int'(ifc.match_cnt), 0);
        chk("sat_clr_flag", int'(ifc.cnt_sat), 0);
        chk("sat_clr_prog", int'(ifc.progress), 0);

        // Reset mid-pattern drops progress; the trailing 1 only starts a new prefix.
        sel = 0;
        bits(3, 3'b110);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_prog", int'(ifa.progress), 0);
        chk("rst_mid_cnt",  int'(ifa.match_cnt), 0);
        bits(1, 1'b1);
        chk("rst_mid_after", int'(ifa.progress), 1);

        idle(2);
        chk("qa_left", qa.size(), 0);
        chk("qb_left", qb.size(), 0);
        chk("qc_left", qc.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
